// File: rtl/psum_mem_arbiter.sv
`default_nettype none
//============================================================================
// Module      : psum_mem_arbiter
// Description : Shares one single-port partial-sum SRAM among three
//               requesters: accumulator writeback (WB, writes), accumulator
//               readback (RB, reads) and host output drain (DR, reads).
//               WB has fixed priority over the readers. RB and DR are
//               round-robined between themselves. A per-reader starvation
//               guard lets a reader that has been blocked for MAX_WAIT
//               consecutive cycles override WB. Read data returns exactly
//               one cycle after the grant to the reader that was granted.
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
// Ports
//   clk, rst_in            clock, synchronous active-high reset
//   wb_valid/ready/addr/data       writeback request channel
//   rb_valid/ready/addr            readback request channel
//   rb_rvalid/rb_rdata             readback return (1-cycle latency)
//   dr_valid/ready/addr            drain request channel
//   dr_rvalid/dr_rdata             drain return (1-cycle latency)
//   mem_en/we/addr/wdata/rdata     single-port psum SRAM interface
//   conflict_cnt           saturating count of contended cycles
//   busy                   request pending or read data still to return
//============================================================================
module psum_mem_arbiter #(
    parameter int ADDR_W   = 20,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4     // legal range 1..15
) (
    input  logic              clk,
    input  logic              rst_in,

    // Accumulator writeback
    input  logic              wb_valid,
    output logic              wb_ready,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,

    // Accumulator readback
    input  logic              rb_valid,
    output logic              rb_ready,
    input  logic [ADDR_W-1:0] rb_addr,
    output logic              rb_rvalid,
    output logic [DATA_W-1:0] rb_rdata,

    // Host output drain
    input  logic              dr_valid,
    output logic              dr_ready,
    input  logic [ADDR_W-1:0] dr_addr,
    output logic              dr_rvalid,
    output logic [DATA_W-1:0] dr_rdata,

    // Psum memory macro
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,

    // Status
    output logic [15:0]       conflict_cnt,
    output logic              busy
);

    //------------------------------------------------------------------------
    // Constants
    //------------------------------------------------------------------------
    localparam logic        c_ptr_rb   = 1'b0;
    localparam logic        c_ptr_dr   = 1'b1;
    localparam logic [3:0]  c_max_wait = 4'(MAX_WAIT);
    localparam logic [3:0]  c_wait_sat = 4'hF;
    localparam logic [15:0] c_cnt_sat  = 16'hFFFF;

    // Tag bit positions: one-hot record of which reader owns the read in flight
    localparam int          c_tag_rb   = 0;
    localparam int          c_tag_dr   = 1;

    //------------------------------------------------------------------------
    // State
    //------------------------------------------------------------------------
    logic        r_rr_ptr_q;
    logic        w_rr_ptr_d;
    logic [3:0]  r_rb_wait_q;
    logic [3:0]  w_rb_wait_d;
    logic [3:0]  r_dr_wait_q;
    logic [3:0]  w_dr_wait_d;
    logic [1:0]  r_tag_q;
    logic [1:0]  w_tag_d;
    logic [15:0] r_conflict_q;
    logic [15:0] w_conflict_d;

    //------------------------------------------------------------------------
    // Combinational arbitration signals
    //------------------------------------------------------------------------
    logic        w_rb_starved;
    logic        w_dr_starved;
    logic        w_gnt_wb;
    logic        w_gnt_rb;
    logic        w_gnt_dr;
    logic        w_rr_prefers_rb;
    logic [1:0]  w_nvalid;
    logic        w_contended;

    assign w_rb_starved    = rb_valid && (r_rb_wait_q >= c_max_wait);
    assign w_dr_starved    = dr_valid && (r_dr_wait_q >= c_max_wait);
    assign w_rr_prefers_rb = (r_rr_ptr_q == c_ptr_rb);

    //------------------------------------------------------------------------
    // Grant selection. Order: starved reader(s), then WB, then the ordinary
    // round-robin among readers. Reset suppresses every grant so nothing
    // reaches the macro while the block is being cleared.
    //------------------------------------------------------------------------
    always_comb begin
        w_gnt_wb = 1'b0;
        w_gnt_rb = 1'b0;
        w_gnt_dr = 1'b0;

        if (!rst_in) begin
            if (w_rb_starved && w_dr_starved) begin
                // Both starved: round-robin pointer breaks the tie
                w_gnt_rb = w_rr_prefers_rb;
                w_gnt_dr = !w_rr_prefers_rb;
            end else if (w_rb_starved) begin
                w_gnt_rb = 1'b1;
            end else if (w_dr_starved) begin
                w_gnt_dr = 1'b1;
            end else if (wb_valid) begin
                w_gnt_wb = 1'b1;
            end else if (rb_valid && dr_valid) begin
                w_gnt_rb = w_rr_prefers_rb;
                w_gnt_dr = !w_rr_prefers_rb;
            end else begin
                // At most one reader valid: it wins regardless of the pointer
                w_gnt_rb = rb_valid;
                w_gnt_dr = dr_valid;
            end
        end
    end

    //------------------------------------------------------------------------
    // Next-state logic
    //------------------------------------------------------------------------
    assign w_nvalid    = {1'b0, wb_valid} + {1'b0, rb_valid} + {1'b0, dr_valid};
    assign w_contended = (w_nvalid >= 2'd2);

    always_comb begin
        // Round-robin pointer moves to the other reader after a reader grant;
        // WB grants and idle cycles leave it alone.
        w_rr_ptr_d = r_rr_ptr_q;
        if (w_gnt_rb) begin
            w_rr_ptr_d = c_ptr_dr;
        end else if (w_gnt_dr) begin
            w_rr_ptr_d = c_ptr_rb;
        end

        // Wait counters track consecutive blocked cycles of a live request.
        // Dropping valid abandons the request, so the count restarts.
        w_rb_wait_d = r_rb_wait_q;
        if (!rb_valid || w_gnt_rb) begin
            w_rb_wait_d = 4'd0;
        end else if (r_rb_wait_q != c_wait_sat) begin
            w_rb_wait_d = r_rb_wait_q + 4'd1;
        end

        w_dr_wait_d = r_dr_wait_q;
        if (!dr_valid || w_gnt_dr) begin
            w_dr_wait_d = 4'd0;
        end else if (r_dr_wait_q != c_wait_sat) begin
            w_dr_wait_d = r_dr_wait_q + 4'd1;
        end

        // Read tag: which reader the macro output belongs to next cycle
        w_tag_d           = 2'b00;
        w_tag_d[c_tag_rb] = w_gnt_rb;
        w_tag_d[c_tag_dr] = w_gnt_dr;

        w_conflict_d = r_conflict_q;
        if (w_contended && (r_conflict_q != c_cnt_sat)) begin
            w_conflict_d = r_conflict_q + 16'd1;
        end
    end

    //------------------------------------------------------------------------
    // Registers
    //------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst_in) begin
            r_rr_ptr_q   <= c_ptr_rb;
            r_rb_wait_q  <= 4'd0;
            r_dr_wait_q  <= 4'd0;
            r_tag_q      <= 2'b00;
            r_conflict_q <= 16'd0;
        end else begin
            r_rr_ptr_q   <= w_rr_ptr_d;
            r_rb_wait_q  <= w_rb_wait_d;
            r_dr_wait_q  <= w_dr_wait_d;
            r_tag_q      <= w_tag_d;
            r_conflict_q <= w_conflict_d;
        end
    end

    //------------------------------------------------------------------------
    // Outputs
    //------------------------------------------------------------------------
    assign wb_ready  = w_gnt_wb;
    assign rb_ready  = w_gnt_rb;
    assign dr_ready  = w_gnt_dr;

    assign mem_en    = w_gnt_wb | w_gnt_rb | w_gnt_dr;
    assign mem_we    = w_gnt_wb;
    assign mem_addr  = w_gnt_rb ? rb_addr :
                       w_gnt_dr ? dr_addr :
                                  wb_addr;
    // Write data is a don't-care on reads, so it is always taken from WB
    assign mem_wdata = wb_data;

    // A read granted just before reset asserts is dropped: the tag register
    // still holds it during the reset cycle, so rvalid is masked by rst_in.
    assign rb_rvalid = r_tag_q[c_tag_rb] & ~rst_in;
    assign dr_rvalid = r_tag_q[c_tag_dr] & ~rst_in;
    assign rb_rdata  = mem_rdata;
    assign dr_rdata  = mem_rdata;

    assign conflict_cnt = r_conflict_q;
    assign busy         = wb_valid | rb_valid | dr_valid | ((|r_tag_q) & ~rst_in);

endmodule
`default_nettype wire

// File: tb/tb_psum_mem_arbiter.sv
`default_nettype none
//============================================================================
// Module      : tb_psum_mem_arbiter
// Description : Self-checking bench for psum_mem_arbiter. A behavioural
//               model of the arbitration rules and a shadow memory predict
//               every output on every cycle; directed sequences add
//               hand-computed literal expectations; randomized traffic and a
//               long saturation run follow.
// Revision    : 1.0 - initial release
//============================================================================
module tb_psum_mem_arbiter;

    localparam int ADDR_W   = 20;
    localparam int DATA_W   = 32;
    localparam int MAX_WAIT = 4;

    logic              clk;
    logic              rst_in;
    logic              wb_valid, rb_valid, dr_valid;
    logic              wb_ready, rb_ready, dr_ready;
    logic [ADDR_W-1:0] wb_addr, rb_addr, dr_addr;
    logic [DATA_W-1:0] wb_data;
    logic              rb_rvalid, dr_rvalid;
    logic [DATA_W-1:0] rb_rdata, dr_rdata;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    bit   [DATA_W-1:0] mem_rdata;
    logic [15:0]       conflict_cnt;
    logic              busy;

    int tests;
    int failed;

    psum_mem_arbiter #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk          (clk),
        .rst_in       (rst_in),
        .wb_valid     (wb_valid),
        .wb_ready     (wb_ready),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .rb_valid     (rb_valid),
        .rb_ready     (rb_ready),
        .rb_addr      (rb_addr),
        .rb_rvalid    (rb_rvalid),
        .rb_rdata     (rb_rdata),
        .dr_valid     (dr_valid),
        .dr_ready     (dr_ready),
        .dr_addr      (dr_addr),
        .dr_rvalid    (dr_rvalid),
        .dr_rdata     (dr_rdata),
        .mem_en       (mem_en),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .conflict_cnt (conflict_cnt),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    //------------------------------------------------------------------------
    // SRAM macro stand-in: write-first across cycles, 1-cycle read latency.
    // When no read happens the output carries junk so a misaligned rvalid
    // is visible.
    //------------------------------------------------------------------------
    bit [DATA_W-1:0] smem [0:1023];

    always @(posedge clk) begin
        if (mem_en === 1'b1 && mem_we === 1'b1) begin
            smem[mem_addr[9:0]] <= mem_wdata;
        end
        if (mem_en === 1'b1 && mem_we === 1'b0) begin
            mem_rdata <= smem[mem_addr[9:0]];
        end else begin
            mem_rdata <= {16'hDEAD, 16'($urandom)};
        end
    end

    //------------------------------------------------------------------------
    // Comparison helper
    //------------------------------------------------------------------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    //------------------------------------------------------------------------
    // Behavioural model: arbitration rules applied directly to the current
    // inputs and a few integers of history. Checks all outputs at every
    // negedge, then advances to what the state will be after the next edge.
    //------------------------------------------------------------------------
    bit [DATA_W-1:0] exp_mem [0:1023];
    int              m_wait_rb, m_wait_dr;
    int              m_rr;          // 0: RB next, 1: DR next
    int              m_conflicts;
    int              m_pend_who;    // 0 none, 1 RB, 2 DR
    bit [DATA_W-1:0] m_pend_data;
    bit              m_valid;

    initial begin
        int  g;   // 0 none, 1 WB, 2 RB, 3 DR
        int  nv;
        bit  rb_st, dr_st;
        bit  e_rbv, e_drv, e_busy;
        m_valid = 1'b0;
        forever begin
            @(negedge clk);
            rb_st = rb_valid && (m_wait_rb >= MAX_WAIT);
            dr_st = dr_valid && (m_wait_dr >= MAX_WAIT);
            if (rst_in)                  g = 0;
            else if (rb_st && dr_st)     g = (m_rr == 0) ? 2 : 3;
            else if (rb_st)              g = 2;
            else if (dr_st)              g = 3;
            else if (wb_valid)           g = 1;
            else if (rb_valid && dr_valid) g = (m_rr == 0) ? 2 : 3;
            else if (rb_valid)           g = 2;
            else if (dr_valid)           g = 3;
            else                         g = 0;
            nv = int'(wb_valid) + int'(rb_valid) + int'(dr_valid);

            e_rbv  = (m_pend_who == 1) && !rst_in;
            e_drv  = (m_pend_who == 2) && !rst_in;
            e_busy = (nv > 0) || (m_pend_who != 0 && !rst_in);

            if (m_valid) begin
                chk("wb_ready", 64'(wb_ready), 64'(g == 1));
                chk("rb_ready", 64'(rb_ready), 64'(g == 2));
                chk("dr_ready", 64'(dr_ready), 64'(g == 3));
                chk("mem_en",   64'(mem_en),   64'(g != 0));
                chk("mem_we",   64'(mem_we),   64'(g == 1));
                if (g == 1) begin
                    chk("mem_addr_wb", 64'(mem_addr),  64'(wb_addr));
                    chk("mem_wdata",   64'(mem_wdata), 64'(wb_data));
                end
                if (g == 2) chk("mem_addr_rb", 64'(mem_addr), 64'(rb_addr));
                if (g == 3) chk("mem_addr_dr", 64'(mem_addr), 64'(dr_addr));
                chk("rb_rvalid", 64'(rb_rvalid), 64'(e_rbv));
                chk("dr_rvalid", 64'(dr_rvalid), 64'(e_drv));
                if (e_rbv) chk("rb_rdata", 64'(rb_rdata), 64'(m_pend_data));
                if (e_drv) chk("dr_rdata", 64'(dr_rdata), 64'(m_pend_data));
                chk("conflict_cnt", 64'(conflict_cnt), 64'(m_conflicts));
                chk("busy", 64'(busy), 64'(e_busy));
            end

            // Advance the model across the coming clock edge
            if (rst_in) begin
                m_wait_rb   = 0;
                m_wait_dr   = 0;
                m_rr        = 0;
                m_conflicts = 0;
                m_pend_who  = 0;
                m_valid     = 1'b1;
            end else begin
                m_pend_who = (g == 2) ? 1 : (g == 3) ? 2 : 0;
                if (g == 2) m_pend_data = exp_mem[rb_addr[9:0]];
                if (g == 3) m_pend_data = exp_mem[dr_addr[9:0]];
                if (g == 1) exp_mem[wb_addr[9:0]] = wb_data;
                if (g == 2) m_rr = 1;
                if (g == 3) m_rr = 0;
                if (nv >= 2 && m_conflicts < 65535) m_conflicts++;
                m_wait_rb = (!rb_valid || g == 2) ? 0 : ((m_wait_rb < 15) ? m_wait_rb + 1 : 15);
                m_wait_dr = (!dr_valid || g == 3) ? 0 : ((m_wait_dr < 15) ? m_wait_dr + 1 : 15);
            end
        end
    end

    //------------------------------------------------------------------------
    // Stimulus helpers: inputs change 1 unit after posedge, checks at negedge
    //------------------------------------------------------------------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic at_sample();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        wb_valid = 1'b0; rb_valid = 1'b0; dr_valid = 1'b0;
        wb_addr  = '0;   rb_addr  = '0;   dr_addr  = '0;
        wb_data  = '0;
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        idle_inputs();
        next_cycle();
        rst_in = 1'b0;
    endtask

    //------------------------------------------------------------------------
    // Main stimulus
    //------------------------------------------------------------------------
    initial begin
        bit wb_r, rb_r, dr_r;
        tests  = 0;
        failed = 0;
        rst_in = 1'b1;
        idle_inputs();
        next_cycle();
        next_cycle();
        rst_in = 1'b0;

        // Reset state
        at_sample();
        chk("reset_conflict_cnt", 64'(conflict_cnt), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        next_cycle();

        // WB-only stream
        for (int i = 0; i < 5; i++) begin
            wb_valid = 1'b1; wb_addr = ADDR_W'(i); wb_data = DATA_W'(10 + i);
            at_sample();
            chk("t1_wb_ready", 64'(wb_ready), 64'd1);
            chk("t1_mem_we", 64'(mem_we), 64'd1);
            chk("t1_mem_addr", 64'(mem_addr), 64'(i));
            chk("t1_mem_wdata", 64'(mem_wdata), 64'(10 + i));
            chk("t1_conflict", 64'(conflict_cnt), 64'd0);
            next_cycle();
        end
        idle_inputs();

        // RB/DR alternation; addr 2 holds 12, addr 3 holds 13
        do_reset();
        for (int k = 0; k < 5; k++) begin
            rb_valid = 1'b1; rb_addr = 20'd2;
            dr_valid = 1'b1; dr_addr = 20'd3;
            at_sample();
            chk("t2_rb_ready", 64'(rb_ready), 64'(k % 2 == 0));
            chk("t2_dr_ready", 64'(dr_ready), 64'(k % 2 == 1));
            if (k >= 1) begin
                chk("t2_rb_rvalid", 64'(rb_rvalid), 64'((k - 1) % 2 == 0));
                chk("t2_dr_rvalid", 64'(dr_rvalid), 64'((k - 1) % 2 == 1));
                if ((k - 1) % 2 == 0) chk("t2_rb_rdata", 64'(rb_rdata), 64'd12);
                else                  chk("t2_dr_rdata", 64'(dr_rdata), 64'd13);
            end
            if (k == 4) chk("t2_conflict", 64'(conflict_cnt), 64'd4);
            next_cycle();
        end
        idle_inputs();

        // Starvation guard against a continuous WB stream
        do_reset();
        for (int k = 0; k < 10; k++) begin
            wb_valid = 1'b1; wb_addr = 20'd100; wb_data = 32'h5000;
            rb_valid = 1'b1; rb_addr = 20'd1;
            at_sample();
            chk("t3_rb_ready", 64'(rb_ready), 64'(k == 4 || k == 9));
            chk("t3_wb_ready", 64'(wb_ready), 64'(!(k == 4 || k == 9)));
            next_cycle();
        end
        idle_inputs();

        // Read-after-write on consecutive cycles
        do_reset();
        wb_valid = 1'b1; wb_addr = 20'd7; wb_data = 32'hABCD;
        at_sample();
        chk("t4_wb_ready", 64'(wb_ready), 64'd1);
        next_cycle();
        idle_inputs();
        rb_valid = 1'b1; rb_addr = 20'd7;
        at_sample();
        chk("t4_rb_ready", 64'(rb_ready), 64'd1);
        next_cycle();
        idle_inputs();
        at_sample();
        chk("t4_rb_rvalid", 64'(rb_rvalid), 64'd1);
        chk("t4_rb_rdata", 64'(rb_rdata), 64'hABCD);
        next_cycle();

        // Reset with a drain read in flight
        do_reset();
        for (int k = 0; k < 2; k++) begin
            wb_valid = 1'b1; wb_addr = 20'd9; wb_data = 32'h9;
            rb_valid = 1'b1; rb_addr = 20'd1;
            next_cycle();
        end
        idle_inputs();
        rb_valid = 1'b1; rb_addr = 20'd1;
        next_cycle();
        idle_inputs();
        dr_valid = 1'b1; dr_addr = 20'd3;
        at_sample();
        chk("t5_dr_ready", 64'(dr_ready), 64'd1);
        next_cycle();
        idle_inputs();
        rst_in = 1'b1;
        at_sample();
        chk("t5_dr_rvalid_c4", 64'(dr_rvalid), 64'd0);
        chk("t5_mem_en_rst", 64'(mem_en), 64'd0);
        next_cycle();
        rst_in = 1'b0;
        rb_valid = 1'b1; dr_valid = 1'b1; rb_addr = 20'd2; dr_addr = 20'd3;
        at_sample();
        chk("t5_dr_rvalid_c5", 64'(dr_rvalid), 64'd0);
        chk("t5_rb_first", 64'(rb_ready), 64'd1);
        chk("t5_conflict", 64'(conflict_cnt), 64'd0);
        next_cycle();
        idle_inputs();

        // Round-robin pointer returns to RB after reset
        do_reset();
        rb_valid = 1'b1; rb_addr = 20'd2;
        next_cycle();
        idle_inputs();
        rst_in = 1'b1;
        next_cycle();
        rst_in = 1'b0;
        rb_valid = 1'b1; dr_valid = 1'b1; rb_addr = 20'd2; dr_addr = 20'd3;
        at_sample();
        chk("t5b_rb_ready", 64'(rb_ready), 64'd1);
        chk("t5b_dr_ready", 64'(dr_ready), 64'd0);
        next_cycle();
        idle_inputs();

        // Randomized traffic; blocked requesters hold their request stable
        wb_r = 1'b0; rb_r = 1'b0; dr_r = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            int wb_pct;
            wb_pct = (n < 1500) ? 55 : 85;
            if (!(wb_valid && !wb_r)) begin
                wb_valid = ($urandom_range(0, 99) < wb_pct);
                wb_addr  = ADDR_W'($urandom_range(0, 15));
                wb_data  = $urandom;
            end
            if (!(rb_valid && !rb_r)) begin
                rb_valid = ($urandom_range(0, 99) < 50);
                rb_addr  = ADDR_W'($urandom_range(0, 15));
            end
            if (!(dr_valid && !dr_r)) begin
                dr_valid = ($urandom_range(0, 99) < 50);
                dr_addr  = ADDR_W'($urandom_range(0, 15));
            end
            rst_in = ($urandom_range(0, 199) == 0);
            at_sample();
            wb_r = wb_ready; rb_r = rb_ready; dr_r = dr_ready;
            next_cycle();
        end
        rst_in = 1'b0;
        idle_inputs();

        // Saturation: everyone requesting for a long time
        do_reset();
        wb_valid = 1'b1; wb_addr = 20'd5; wb_data = 32'h55;
        rb_valid = 1'b1; rb_addr = 20'd6;
        dr_valid = 1'b1; dr_addr = 20'd7;
        repeat (70000) next_cycle();
        at_sample();
        chk("t6_conflict_sat", 64'(conflict_cnt), 64'hFFFF);
        next_cycle();
        idle_inputs();
        next_cycle();
        next_cycle();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire
